uart_frame_assembler: RTL and testbench
=======================================

// Module: uart_frame_assembler
// PURPOSE
//  Upstream stage of frame_buffer. Collects the byte stream from the UART receiver into a
//  complete 64-byte cube frame and drives frame_cube_uart.
//  Frames are double-buffered: a partial or corrupt frame never reaches the output, so
//  frame_buffer always displays the last good frame.
// PARAMETERS
//  HEADER          8'hF2      sync byte that opens a frame
//  N_BYTES         64         payload bytes per frame (one per cube column/row word)
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between accepted bytes inside a frame (20 ms @ 50 MHz)
// PORTS
//  clk              in   1      system clock
//  rst              in   1      asynchronous reset, active-low
//  rx_data          in   8      byte from UART receiver
//  rx_valid         in   1      1-cycle strobe; rx_data valid when high
//  frame_cube_uart  out  8x64   last committed frame, unpacked [7:0] x [63:0]
//  frame_done       out  1      1-cycle pulse: new frame committed
//  frame_err        out  1      1-cycle pulse: checksum mismatch or inter-byte timeout
//  have_frame       out  1      sticky high after first commit (display_mode source)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; idx=0; sum=0; timer=0.
//   frame_cube_uart, stage buffer, frame_done, frame_err and have_frame all clear to 0.
//  Frame format: HEADER, then N_BYTES payload bytes (byte k -> frame_cube_uart[k]),
//   then CHK. CHK = (sum of payload bytes) mod 256.
//  IDLE:
//   - rx_valid && rx_data==HEADER -> PAYLOAD; idx=0, sum=0, timer=0.
//   - Any other byte is discarded silently; no err pulse.
//  PAYLOAD, on each rx_valid:
//   - stage[idx]<=rx_data; sum<=sum+rx_data (8-bit wrap); idx<=idx+1.
//   - On the byte with idx==N_BYTES-1 -> CHECK.
//   - HEADER value is ordinary data here; no resync.
//  CHECK, on rx_valid:
//   - rx_data==sum: frame_cube_uart<=stage (all 64 at the same edge); frame_done=1 next
//     cycle; have_frame<=1.
//   - Otherwise: output unchanged; frame_err=1 next cycle.
//   - Either way -> IDLE.
//  Timeout: in PAYLOAD/CHECK, timer counts cycles without rx_valid and clears on rx_valid.
//   At timer==TIMEOUT_CYCLES-1 -> IDLE; frame_err pulse; output untouched.
//   Timeout and rx_valid in the same cycle: the byte wins and the timer clears.
//  Latency: the output updates on the clk edge that samples a valid CHK byte.
//   frame_done is high during the cycle after that edge.
//  frame_done and frame_err are never high together. Each is exactly 1 cycle.
//  Back-to-back frames: rx_valid on consecutive cycles must be accepted. A HEADER in the
//   cycle right after CHK starts the next frame.
//  Reset asserted mid-frame: the stage buffer is discarded and the output clears to 0.
//  Widths: idx $clog2(N_BYTES); timer $clog2(TIMEOUT_CYCLES).
// STRUCTURE
//  Shared package cube_pkg:
//   - localparams CUBE_BYTES=64, UART_HEADER=8'hF2.
//   - typedef logic [7:0] cube_frame_t [CUBE_BYTES-1:0], reused by frame_buffer.
//   - state enum {IDLE, PAYLOAD, CHECK}.
//  One sub-module: frame_timeout_timer (counter with clear/enable; emits expire pulse).
//  FSM, stage buffer and output buffer are kept in this module.
// TESTING
//  1 Reset: assert rst=0 mid-frame -> all outputs 0 immediately. Release -> IDLE; 0x00 byte ignored.
//  2 Good frame: F2, bytes k=0..63 value k, CHK=0xE0 (2016 mod 256)
//    -> frame_cube_uart[k]==k; one frame_done pulse; have_frame=1.
//  3 Bad checksum: same frame with CHK=0xE1 -> frame_err pulse; output keeps previous frame.
//  4 Timeout: F2 + 10 bytes, then idle TIMEOUT_CYCLES (override to 100)
//    -> frame_err at cycle 100; a following valid frame commits normally.
//  5 Header in payload: F2, payload all 0xF2, CHK=0x80 -> commits 64x0xF2.
//    Junk bytes 0x11,0x22 before F2 are ignored.
//  6 Back-to-back: two valid frames, rx_valid every cycle -> two frame_done pulses 66 cycles apart.
//    Second frame contents are visible.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube definitions: frame geometry, UART sync byte, frame type and
// the assembler state encoding.
package cube_pkg;

  localparam int          CUBE_BYTES  = 64;
  localparam logic [7:0]  UART_HEADER = 8'hF2;

  typedef logic [7:0] cube_frame_t [CUBE_BYTES-1:0];

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } asm_state_e;

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte stream in, committed frame and status pulses out, for the UART frame assembler.
interface uart_frame_assembler_if;
  import cube_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_valid;
  cube_frame_t frame_cube_uart;
  logic        frame_done;
  logic        frame_err;
  logic        have_frame;

  modport master (
    output rx_data, rx_valid,
    input  frame_cube_uart, frame_done, frame_err, have_frame
  );

  modport slave (
    input  rx_data, rx_valid,
    output frame_cube_uart, frame_done, frame_err, have_frame
  );

endinterface

// File: rtl/uart_frame_assembler_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches CYCLES-1.
module frame_timeout_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int             W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0]   LAST = W'(CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle clears the count, so it wins.
  assign expire_o = enable_i && !clear_i && (count_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles HEADER + payload + checksum byte streams into a double-buffered cube
// frame; only frames with a matching checksum reach the output.
module uart_frame_assembler
  import cube_pkg::*;
#(
  parameter logic [7:0] HEADER         = UART_HEADER,
  parameter int         N_BYTES        = CUBE_BYTES,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_assembler_if.slave  bus
);

  localparam int               IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  asm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             have_frame_q, have_frame_d;
  logic             stage_we;
  logic             busy;
  logic             timer_expire;

  cube_frame_t stage_q;
  cube_frame_t frame_q;

  assign busy = (state_q != IDLE);

  frame_timeout_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (bus.rx_valid || !busy),
    .enable_i (busy),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    stage_we     = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    have_frame_d = have_frame_q;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HEADER) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      PAYLOAD: begin
        // HEADER is plain data here; a frame never resyncs mid-payload.
        if (bus.rx_valid) begin
          stage_we = 1'b1;
          sum_d    = sum_q + bus.rx_data;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end
        end else if (timer_expire) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          state_d = IDLE;
          if (bus.rx_data == sum_q) begin
            frame_done_d = 1'b1;
            have_frame_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end else if (timer_expire) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sum_q        <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      have_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      have_frame_q <= have_frame_d;
    end
  end

  // NOTE: both buffers are reset on purpose: a reset must blank the display and drop any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CUBE_BYTES; i++) begin
        stage_q[i] <= '0;
        frame_q[i] <= '0;
      end
    end else begin
      if (stage_we) begin
        stage_q[idx_q] <= bus.rx_data;
      end
      // The stage is complete before CHK arrives, so all bytes commit on one edge.
      if (frame_done_d) begin
        frame_q <= stage_q;
      end
    end
  end

  assign bus.frame_cube_uart = frame_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.frame_err       = frame_err_q;
  assign bus.have_frame      = have_frame_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomised scoreboard bench for uart_frame_assembler with directed boundary cases.
module tb_uart_frame_assembler;
  import cube_pkg::*;

  localparam int T = 100;

  typedef struct packed {
    logic         is_err;
    logic [511:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_assembler_if bus();

  uart_frame_assembler #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int err_cyc       = -1;
  int done_cyc      = -1;
  int prev_done_cyc = -1;

  exp_t         exp_q[$];
  logic [511:0] model_good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [511:0] pack(input cube_frame_t f);
    logic [511:0] p;
    for (int k = 0; k < CUBE_BYTES; k++) p[8*k +: 8] = f[k];
    return p;
  endfunction

  function automatic logic [7:0] csum(input logic [511:0] pl);
    int s = 0;
    for (int k = 0; k < CUBE_BYTES; k++) s += int'(pl[8*k +: 8]);
    return 8'(s % 256);
  endfunction

  // Monitor: pops an expectation on every status pulse and tracks the visible frame.
  logic [511:0] mon_frame = '0;
  logic         have_exp  = 1'b0;
  logic         prev_evt  = 1'b0;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      mon_frame = '0;
      have_exp  = 1'b0;
      prev_evt  = 1'b0;
    end else begin
      if (bus.frame_done || bus.frame_err) begin
        check("single_cycle_exclusive_pulse", {prev_evt, bus.frame_done & bus.frame_err}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {bus.frame_done, bus.frame_err}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", {bus.frame_done, bus.frame_err}, mon_e.is_err ? 2'b01 : 2'b10);
          mon_frame = mon_e.frame;
          if (!mon_e.is_err) have_exp = 1'b1;
        end
        if (bus.frame_done) begin
          prev_done_cyc = done_cyc;
          done_cyc      = cyc;
        end
        if (bus.frame_err) err_cyc = cyc;
      end
      prev_evt = bus.frame_done | bus.frame_err;
      check("frame_out", pack(bus.frame_cube_uart), mon_frame);
      check("have_frame", bus.have_frame, have_exp);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [511:0] pl, input logic [7:0] chk, input int max_gap);
    exp_t e;
    if (chk == csum(pl)) begin
      e.is_err   = 1'b0;
      e.frame    = pl;
      model_good = pl;
    end else begin
      e.is_err = 1'b1;
      e.frame  = model_good;
    end
    exp_q.push_back(e);
    send_byte(UART_HEADER);
    for (int k = 0; k < CUBE_BYTES; k++) begin
      send_byte(pl[8*k +: 8]);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
    send_byte(chk);
  endtask

  task automatic send_timeout(input int n_payload);
    exp_t e;
    int   last_cyc;
    e.is_err = 1'b1;
    e.frame  = model_good;
    exp_q.push_back(e);
    send_byte(UART_HEADER);
    for (int k = 0; k < n_payload; k++) send_byte(8'($urandom));
    last_cyc = cyc;
    idle(T + 5);
    check("timeout_latency", err_cyc - last_cyc, T);
  endtask

  function automatic logic [511:0] rand_frame();
    logic [511:0] p;
    for (int k = 0; k < CUBE_BYTES; k++) p[8*k +: 8] = 8'($urandom);
    return p;
  endfunction

  logic [511:0] pl;
  logic [511:0] pl2;
  logic [7:0]   junk;
  int           r;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 rst = 1'b0;
    #10;
    check("reset_frame", pack(bus.frame_cube_uart), '0);
    check("reset_flags", {bus.frame_done, bus.frame_err, bus.have_frame}, 3'b000);
    @(posedge clk);
    #3 rst = 1'b1;
    idle(2);
    send_byte(8'h00);
    idle(3);

    // Counting frame: byte k = k, checksum 2016 mod 256.
    for (int k = 0; k < CUBE_BYTES; k++) pl[8*k +: 8] = 8'(k);
    send_frame(pl, 8'hE0, 0);
    idle(3);
    check("count_frame", pack(bus.frame_cube_uart), pl);
    check("count_have", bus.have_frame, 1'b1);

    send_frame(pl, 8'hE1, 0);
    idle(3);
    check("bad_chk_keeps_frame", pack(bus.frame_cube_uart), pl);

    send_timeout(10);
    pl2 = rand_frame();
    send_frame(pl2, csum(pl2), 0);
    idle(3);
    check("after_timeout_frame", pack(bus.frame_cube_uart), pl2);

    send_byte(8'h11);
    send_byte(8'h22);
    pl = {64{8'hF2}};
    send_frame(pl, 8'h80, 0);
    idle(3);
    check("header_in_payload", pack(bus.frame_cube_uart), pl);

    pl  = rand_frame();
    pl2 = rand_frame();
    send_frame(pl, csum(pl), 0);
    send_frame(pl2, csum(pl2), 0);
    idle(3);
    check("back_to_back_spacing", done_cyc - prev_done_cyc, 66);
    check("back_to_back_second", pack(bus.frame_cube_uart), pl2);

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(3, 0)) begin
        junk = 8'($urandom);
        if (junk == UART_HEADER) junk = 8'h00;
        send_byte(junk);
      end
      r  = $urandom_range(9, 0);
      pl = rand_frame();
      if (r < 1) begin
        send_timeout($urandom_range(64, 0));
      end else if (r < 3) begin
        send_frame(pl, csum(pl) + 8'(1 + $urandom_range(254, 0)), $urandom_range(5, 0));
      end else begin
        send_frame(pl, csum(pl), $urandom_range(5, 0));
      end
      idle($urandom_range(2, 0));
    end

    // Reset in the middle of a frame blanks everything immediately.
    pl = rand_frame();
    send_frame(pl, csum(pl), 0);
    idle(2);
    send_byte(UART_HEADER);
    for (int k = 0; k < 20; k++) send_byte(8'($urandom));
    #3 rst = 1'b0;
    #1;
    check("midframe_reset_frame", pack(bus.frame_cube_uart), '0);
    check("midframe_reset_flags", {bus.frame_done, bus.frame_err, bus.have_frame}, 3'b000);
    model_good = '0;
    idle(2);
    #2 rst = 1'b1;
    idle(2);
    send_byte(8'h00);
    idle(3);
    pl = rand_frame();
    send_frame(pl, csum(pl), 1);
    idle(3);
    check("post_reset_frame", pack(bus.frame_cube_uart), pl);

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
